// File: rtl/envelope_trigger.sv
// envelope_trigger
//
// Per-channel windowed peak-to-peak detector with a hysteresis comparator
// and an edge-triggered, holdoff-limited trigger pulse.
//
// Each channel's sample stream is split into non-overlapping windows of
// WINDOW samples. The window's (max - min) is reported on the p2p_* outputs.
// That amplitude drives a per-channel Schmitt comparator. Selected edges of
// the comparator produce a one-cycle trigger.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   axiiv           sample valid (no backpressure)
//   axiid           signed sample, WIDTH bits
//   axiic           channel index of the sample, CW bits
//   low_threshold   unsigned, comparator clears when p2p is below it
//   high_threshold  unsigned, comparator sets when p2p is above it
//   edge_mode       00 falling, 01 rising, 10 both, 11 none
//   p2p_valid       one-cycle strobe, window result ready
//   p2p_data        unsigned peak-to-peak of the completed window
//   p2p_channel     channel of p2p_data
//   triggered       one-cycle trigger pulse
//   trigger_channel channel that triggered
//   state           per-channel comparator state
module envelope_trigger #(
    parameter int WIDTH    = 8,
    parameter int WINDOW   = 500,
    parameter int CHANNELS = 1,
    parameter int HOLDOFF  = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                axiiv,
    input  logic [WIDTH-1:0]    axiid,
    input  logic [CW-1:0]       axiic,
    input  logic [WIDTH:0]      low_threshold,
    input  logic [WIDTH:0]      high_threshold,
    input  logic [1:0]          edge_mode,
    output logic                p2p_valid,
    output logic [WIDTH:0]      p2p_data,
    output logic [CW-1:0]       p2p_channel,
    output logic                triggered,
    output logic [CW-1:0]       trigger_channel,
    output logic [CHANNELS-1:0] state
);

    localparam int CNTW = $clog2(WINDOW);
    localparam int HW   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [CNTW-1:0]         CNT_LAST  = CNTW'(WINDOW - 1);
    localparam logic [HW-1:0]           HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [CW:0]             CH_LIMIT  = (CW + 1)'(CHANNELS);
    // Running min starts at the most positive value and running max at the
    // most negative, so the first sample of a window always replaces both.
    localparam logic signed [WIDTH-1:0] MIN_INIT  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MAX_INIT  = {1'b1, {(WIDTH - 1){1'b0}}};

    // Per-channel state
    logic [CNTW-1:0]         cnt_reg  [CHANNELS];
    logic signed [WIDTH-1:0] min_reg  [CHANNELS];
    logic signed [WIDTH-1:0] max_reg  [CHANNELS];
    logic [HW-1:0]           hold_reg [CHANNELS];
    logic [CHANNELS-1:0]     state_reg;

    // Output registers
    logic                    p2p_valid_reg;
    logic [WIDTH:0]          p2p_data_reg;
    logic [CW-1:0]           p2p_channel_reg;
    logic                    triggered_reg;
    logic [CW-1:0]           trigger_channel_reg;

    // Datapath for the channel addressed this cycle
    logic                    sample_ok;
    logic signed [WIDTH-1:0] sample_s;
    logic [CNTW-1:0]         cur_cnt;
    logic signed [WIDTH-1:0] cur_min;
    logic signed [WIDTH-1:0] cur_max;
    logic [HW-1:0]           cur_hold;
    logic                    cur_state;
    logic signed [WIDTH-1:0] min_next;
    logic signed [WIDTH-1:0] max_next;
    logic                    win_done;
    logic [WIDTH:0]          p2p_next;
    logic                    state_next;
    logic                    edge_ok;
    logic                    fire;
    logic [HW-1:0]           hold_next;

    assign sample_ok = axiiv && ({1'b0, axiic} < CH_LIMIT);
    assign sample_s  = signed'(axiid);

    always_comb begin
        cur_cnt    = '0;
        cur_min    = MIN_INIT;
        cur_max    = MAX_INIT;
        cur_hold   = '0;
        cur_state  = 1'b0;
        min_next   = MIN_INIT;
        max_next   = MAX_INIT;
        win_done   = 1'b0;
        p2p_next   = '0;
        state_next = 1'b0;
        edge_ok    = 1'b0;
        fire       = 1'b0;
        hold_next  = '0;

        if (sample_ok) begin
            cur_cnt   = cnt_reg[axiic];
            cur_min   = min_reg[axiic];
            cur_max   = max_reg[axiic];
            cur_hold  = hold_reg[axiic];
            cur_state = state_reg[axiic];
        end

        min_next = (sample_s < cur_min) ? sample_s : cur_min;
        max_next = (sample_s > cur_max) ? sample_s : cur_max;
        win_done = sample_ok && (cur_cnt == CNT_LAST);

        // Sign-extend to WIDTH+1 bits: the difference of two WIDTH-bit
        // signed values with max >= min always fits as an unsigned result.
        p2p_next = {max_next[WIDTH-1], max_next} - {min_next[WIDTH-1], min_next};

        // Low check first so it wins when the thresholds are inverted.
        if (p2p_next < low_threshold) begin
            state_next = 1'b0;
        end else if (p2p_next > high_threshold) begin
            state_next = 1'b1;
        end else begin
            state_next = cur_state;
        end

        case (edge_mode)
            2'b00:   edge_ok = cur_state & ~state_next;
            2'b01:   edge_ok = ~cur_state & state_next;
            2'b10:   edge_ok = cur_state ^ state_next;
            default: edge_ok = 1'b0;
        endcase

        fire = win_done && edge_ok && (cur_hold == '0);

        // Holdoff only counts down on completions that do not trigger.
        if (fire) begin
            hold_next = HOLD_LOAD;
        end else if (cur_hold != '0) begin
            hold_next = cur_hold - 1'b1;
        end else begin
            hold_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_reg[i]  <= '0;
                min_reg[i]  <= MIN_INIT;
                max_reg[i]  <= MAX_INIT;
                hold_reg[i] <= '0;
            end
            state_reg           <= '0;
            p2p_valid_reg       <= 1'b0;
            p2p_data_reg        <= '0;
            p2p_channel_reg     <= '0;
            triggered_reg       <= 1'b0;
            trigger_channel_reg <= '0;
        end else begin
            p2p_valid_reg <= win_done;
            triggered_reg <= fire;
            if (win_done) begin
                p2p_data_reg    <= p2p_next;
                p2p_channel_reg <= axiic;
            end
            if (fire) begin
                trigger_channel_reg <= axiic;
            end
            if (sample_ok) begin
                if (win_done) begin
                    cnt_reg[axiic]   <= '0;
                    min_reg[axiic]   <= MIN_INIT;
                    max_reg[axiic]   <= MAX_INIT;
                    hold_reg[axiic]  <= hold_next;
                    state_reg[axiic] <= state_next;
                end else begin
                    cnt_reg[axiic] <= cur_cnt + 1'b1;
                    min_reg[axiic] <= min_next;
                    max_reg[axiic] <= max_next;
                end
            end
        end
    end

    assign p2p_valid       = p2p_valid_reg;
    assign p2p_data        = p2p_data_reg;
    assign p2p_channel     = p2p_channel_reg;
    assign triggered       = triggered_reg;
    assign trigger_channel = trigger_channel_reg;
    assign state           = state_reg;

endmodule

// File: doc/envelope_trigger.md
# envelope_trigger

Multi-channel, run-time-configurable successor to the lookback min/max Schmitt filter. It splits each channel's incoming signed sample stream into non-overlapping windows of WINDOW samples and computes each window's peak-to-peak amplitude (max − min). It runs that amplitude through a per-channel hysteresis comparator and emits a one-cycle trigger pulse on selected comparator edges, with optional holdoff. It sits directly after the sample source (ADC/decimator) and feeds the capture/timing logic, which also consumes the amplitude stream.

## Interface
- WIDTH, 8: sample width in bits, two's complement, ≥2.
- WINDOW, 500: samples per window per channel, ≥2.
- CHANNELS, 1: number of time-multiplexed channels, ≥1; CW = max(1, $clog2(CHANNELS)).
- HOLDOFF, 0: number of completed windows on a channel during which further triggers on that channel are suppressed after a trigger.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- axiiv  in  1  sample valid; sample accepted every cycle it is high (no backpressure).
- axiid  in  WIDTH  signed sample.
- axiic  in  CW  channel index of the sample.
- low_threshold  in  WIDTH+1  unsigned; comparator clears below this value.
- high_threshold  in  WIDTH+1  unsigned; comparator sets above this value.
- edge_mode  in  2  selects which comparator edges trigger: 00 falling (1→0), 01 rising, 10 both, 11 none.
- p2p_valid  out  1  one-cycle strobe, window result ready.
- p2p_data  out  WIDTH+1  unsigned peak-to-peak of the completed window.
- p2p_channel  out  CW  channel of p2p_data.
- triggered  out  1  one-cycle trigger pulse.
- trigger_channel  out  CW  channel that triggered.
- state  out  CHANNELS  current per-channel comparator state.

## Operation
- Per-channel registers:
  - sample counter, 0..WINDOW-1;
  - running min, reset to 2^(WIDTH-1)−1;
  - running max, reset to −2^(WIDTH-1);
  - comparator state, reset to 0;
  - holdoff counter, reset to 0.
- Accepted sample (axiiv=1, axiic<CHANNELS):
  - next_min = min(min, axiid), next_max = max(max, axiid); min and max are checked independently, both can update on one sample.
  - If counter ≠ WINDOW-1: store next_min/next_max, counter+1.
  - If counter = WINDOW-1 (window completion, this sample included):
    - p2p = next_max − next_min, computed in WIDTH+1 bits so it never overflows (max 2^WIDTH−1);
    - counter → 0, min/max → reset values;
    - comparator update.
- Comparator update, thresholds sampled at the completion cycle:
  - p2p < low_threshold → state 0;
  - else p2p > high_threshold → state 1;
  - else state holds. Values equal to a threshold hold. The low check has priority if low > high.
- Edge detection: an edge occurs when new state ≠ old state. It is qualified by edge_mode at the completion cycle.
- Holdoff:
  - If the channel's holdoff counter = 0 and the edge is qualified: emit trigger, load holdoff counter with HOLDOFF.
  - Otherwise the trigger is suppressed; state still updates.
  - The holdoff counter decrements by one at every window completion on that channel that does not emit a trigger. It saturates at 0.
- axiic ≥ CHANNELS: the sample is dropped with no state change.
- Channels are fully independent; any interleaving is legal, including the same channel every cycle.

## Timing
- Sample accepted at cycle k with window completion → p2p_valid, p2p_data, p2p_channel, triggered, trigger_channel, and state[ch] are all registered and updated at cycle k+1.
- p2p_valid and triggered are high for exactly one cycle per completion. At most one completion per cycle, so there is no output contention.
- p2p_data, p2p_channel, and trigger_channel hold their last values between strobes.
- Full throughput: one sample per cycle sustained, with no bubbles required between windows.
- Reset (rst_n=0, any time including mid-window) immediately clears:
  - all counters, state, and holdoff counters;
  - p2p_valid=0, triggered=0, p2p_data=0, p2p_channel=0, trigger_channel=0;
  - min/max to their reset values.
- The first sample after rst_n rises starts a fresh window on its channel.
- Threshold or edge_mode changes take effect at the next completion. Partially accumulated windows are unaffected.

## Test plan
Bench configuration: WIDTH=8, WINDOW=4, CHANNELS=2, low=37, high=74, HOLDOFF=0 unless stated.
- Reset: hold rst_n=0 → all outputs 0, state=00. Pulse rst_n low after ch0 samples 10, −10 (mid-window), then send ch0 100, −100, 0, 0 → p2p=200, counted from a fresh window.
- Rising edge: ch0 samples −50, 50, 0, 10 back-to-back, edge_mode=01 → cycle after 4th sample: p2p_valid=1, p2p_data=100, state[0]=1, triggered=1, trigger_channel=0. Repeat with edge_mode=00 → no trigger.
- Falling edge plus hysteresis: from state 1, windows with p2p 50, then 74, then 37 → state holds 1 with no trigger. Next window 0, 5, −5, 0 (p2p=10) with edge_mode=00 → state 0, triggered=1.
- Interleaving and extremes: alternate ch0/ch1 every cycle; ch1 gets −128, 127, 0, 0 → p2p_channel=1, p2p_data=255 (no overflow), trigger_channel=1. ch0 results are unaffected. axiic=2 samples are ignored.
- Holdoff: HOLDOFF=1, edge_mode=10, ch0 window p2p alternating 100, 10, 100 → trigger on 1st completion only, suppressed on 2nd, trigger on 3rd. state follows 1, 0, 1.
